// File: rtl/snake_body_ctrl.sv
// Snake body: direction latch, step timer, segment shift register, wall/self collision and growth.
// Latency: head, length, eat and game_over are registered one edge after a step; body_hit is combinational; no backpressure.
module snake_body_ctrl #(
    parameter int TICK_DIV = 12500000,
    parameter int MAX_LEN  = 16
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic [5:0] apple_x,
    input  logic [5:0] apple_y,
    input  logic [5:0] pix_x,
    input  logic [5:0] pix_y,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic       body_hit,
    output logic [4:0] length,
    output logic       eat,
    output logic       game_over
);
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [5:0]    r_seg_x [MAX_LEN];
    logic [5:0]    r_seg_y [MAX_LEN];
    logic [4:0]    r_len;
    logic [1:0]    r_dir;
    logic [1:0]    r_last_dir;
    logic [CW-1:0] r_tick;
    logic          r_eat;
    logic          r_over;

    logic       w_run, w_step, w_wall, w_grow, w_self, w_req_vld, w_hit;
    logic [5:0] w_nx, w_ny;
    logic [4:0] w_lim;
    logic [1:0] w_req, w_ref;

    assign w_run  = (mode == 2'd1) && !r_over;
    assign w_step = w_run && (r_tick == CW'(TICK_DIV - 1));

    always_comb begin
        w_nx = r_seg_x[0];
        w_ny = r_seg_y[0];
        case (r_dir)
            DIR_UP:    w_ny = r_seg_y[0] - 6'd1;
            DIR_DOWN:  w_ny = r_seg_y[0] + 6'd1;
            DIR_LEFT:  w_nx = r_seg_x[0] - 6'd1;
            default:   w_nx = r_seg_x[0] + 6'd1;
        endcase
    end

    assign w_wall = (w_nx == 6'd0) || (w_nx == 6'd39) || (w_ny == 6'd0) || (w_ny == 6'd29);
    assign w_grow = (w_nx == apple_x) && (w_ny == apple_y);
    // Without growth the tail cell is vacated by this very step, so it is not an obstacle.
    assign w_lim  = w_grow ? r_len : r_len - 5'd1;

    always_comb begin
        w_self = 1'b0;
        w_hit  = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (5'(i) < w_lim && r_seg_x[i] == w_nx && r_seg_y[i] == w_ny)
                w_self = 1'b1;
            if (i > 0 && 5'(i) < r_len && r_seg_x[i] == pix_x && r_seg_y[i] == pix_y)
                w_hit = 1'b1;
        end
    end

    always_comb begin
        w_req_vld = key_up | key_down | key_left | key_right;
        if (key_up)        w_req = DIR_UP;
        else if (key_down) w_req = DIR_DOWN;
        else if (key_left) w_req = DIR_LEFT;
        else               w_req = DIR_RIGHT;
    end

    // On a step edge last_dir becomes the current dir, so reversal is judged against that.
    assign w_ref = w_step ? r_dir : r_last_dir;

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < 3) ? 6'(10 - i) : 6'd0;
                r_seg_y[i] <= (i < 3) ? 6'd15 : 6'd0;
            end
            r_len      <= 5'd3;
            r_dir      <= DIR_RIGHT;
            r_last_dir <= DIR_RIGHT;
            r_tick     <= '0;
            r_eat      <= 1'b0;
            r_over     <= 1'b0;
        end else if (mode != 2'd1) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < 3) ? 6'(10 - i) : 6'd0;
                r_seg_y[i] <= (i < 3) ? 6'd15 : 6'd0;
            end
            r_len      <= 5'd3;
            r_dir      <= DIR_RIGHT;
            r_last_dir <= DIR_RIGHT;
            r_tick     <= '0;
            r_eat      <= 1'b0;
            r_over     <= 1'b0;
        end else if (r_over) begin
            r_tick <= '0;
            r_eat  <= 1'b0;
        end else begin
            r_eat  <= 1'b0;
            r_tick <= w_step ? '0 : r_tick + CW'(1);
            if (w_req_vld && (w_req != (w_ref ^ 2'b01)))
                r_dir <= w_req;
            if (w_step) begin
                if (w_wall || w_self) begin
                    r_over <= 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        r_seg_x[i] <= r_seg_x[i-1];
                        r_seg_y[i] <= r_seg_y[i-1];
                    end
                    r_seg_x[0] <= w_nx;
                    r_seg_y[0] <= w_ny;
                    r_last_dir <= r_dir;
                    r_eat      <= w_grow;
                    if (w_grow && r_len < 5'(MAX_LEN))
                        r_len <= r_len + 5'd1;
                end
            end
        end
    end

    assign head_x    = r_seg_x[0];
    assign head_y    = r_seg_y[0];
    assign body_hit  = w_hit;
    assign length    = r_len;
    assign eat       = r_eat;
    assign game_over = r_over;
endmodule

// File: doc/snake_body_ctrl.md
SNAKE_BODY_CTRL -- requirements
Module: snake_body_ctrl

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 12500000, giving the number of clk_50MHz cycles per snake step (4 Hz).
REQ-002 SHALL provide parameter MAX_LEN, default 16, giving the number of segment registers, head included.
REQ-003 clk_50MHz  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mode  input  2  game mode; 1 = play, any other value = hold the start position.
REQ-006 key_up, key_down, key_left, key_right  input  1 each  debounced direction request levels.
REQ-007 apple_x, apple_y  input  6 each  current apple grid cell.
REQ-008 pix_x, pix_y  input  6 each  grid cell being queried by the display.
REQ-009 head_x, head_y  output  6 each  registered head cell (segment 0).
REQ-010 body_hit  output  1  combinational; 1 when (pix_x, pix_y) equals any active segment 1..length-1.
REQ-011 length  output  5  registered active segment count, head included.
REQ-012 eat  output  1  registered one-cycle pulse on a step that lands on the apple.
REQ-013 game_over  output  1  registered sticky collision flag.

Function
REQ-014 Playfield: legal cells are x 1..38 and y 1..28; x=0, x=39, y=0 and y=29 are wall cells.
REQ-015 Direction register: 2-bit value with states UP, DOWN, LEFT and RIGHT.
REQ-016 Key sampling: keys are sampled every cycle with priority up > down > left > right.
REQ-017 A request SHALL be ignored when it is opposite to last_dir, the direction used by the most recent step; this blocks double-reversal within one tick.
REQ-018 Tick counter: counts 0..TICK_DIV-1 only while mode==1 and game_over==0; it is cleared otherwise.
REQ-019 A step occurs on the cycle the tick counter equals TICK_DIV-1; the counter then wraps to 0.
REQ-020 Step candidate: next = head plus unit offset of dir, where UP is y-1, DOWN is y+1, LEFT is x-1 and RIGHT is x+1.
REQ-021 Wall collision: if next is a wall cell, then game_over<=1 and no segment, length or eat change occurs.
REQ-022 grow: grow = (next == apple).
REQ-023 Self-collision set without grow: next is compared with segments 0..length-2, because the tail vacates on a normal step.
REQ-024 Self-collision set with grow: next is compared with segments 0..length-1.
REQ-025 Self collision: on any match, game_over<=1 and no state changes.
REQ-026 Legal step: seg[i]<=seg[i-1] for i=1..MAX_LEN-1, seg[0]<=next, and last_dir<=dir.
REQ-027 On a legal step with grow, eat<=1 for exactly one cycle and length<=length+1, saturating at MAX_LEN.
REQ-028 At saturation eat still pulses and the tail is dropped.
REQ-029 eat SHALL be 0 on every non-step cycle.
REQ-030 head_x/head_y SHALL update on the same edge as the eat pulse, so the apple generator sees head==apple exactly once.
REQ-031 game_over SHALL remain 1, with the snake frozen, until mode!=1 or rst_n=0.
REQ-032 mode!=1: synchronously load the start state defined in REQ-033, clear game_over and the tick counter.
REQ-033 Start state: segments (10,15), (9,15) and (8,15); length=3; dir=RIGHT; last_dir=RIGHT.
REQ-034 When mode returns to 1, the first step occurs TICK_DIV cycles later.
REQ-035 Segments at index >= length hold stale values and SHALL never affect body_hit or collision.

Reset
REQ-036 While rst_n=0: the start state of REQ-033, head_x=10, head_y=15, length=3, eat=0, game_over=0, and tick counter 0.
REQ-037 rst_n asserted mid-step or mid-game SHALL abort immediately, with no partial segment shift visible after release.

Verification (TICK_DIV=4)
REQ-038 Reset, then query pix (9,15), (8,15) and (7,15) -> body_hit=1, 1, 0; head (10,15); length 3.
REQ-039 mode=1, no keys -> head (11,15) after 4 cycles and (12,15) after 8; eat=0 throughout.
REQ-040 key_left pulse while moving RIGHT -> ignored and head (11,15); then key_up -> next step head (11,14).
REQ-041 Apple (11,15), mode=1 -> first step eat=1 for one cycle, length 4, body_hit at (8,15) still 1.
REQ-042 Run RIGHT to head (38,15), then one more tick -> game_over=1, head stays (38,15), no later steps; mode=0 -> start state and game_over=0.
REQ-043 Length 5, head (20,15), moves UP, LEFT, DOWN -> third step sets game_over.
REQ-044 Repeat REQ-043 with length 4 -> no collision (tail vacated) and head (19,15).
